// File: rtl/receiver_pkg.sv
// Shared switch definitions: FSM state encodings and flit bus sizing.
// The transmit stage imports the same package.
package receiver_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;

    // Flit layout: payload, destination address, plus one control bit.
    function automatic int bus_size(input int data_size, input int addr_size);
        return data_size + addr_size + 1;
    endfunction

endpackage

// File: rtl/receiver_rr_arbiter.sv
// Combinational round-robin selector: picks the first requester at or after ptr,
// wrapping from N-1 back to 0.
module rr_arbiter #(
    parameter int N = 5,
    parameter int W = 3
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any_grant
);

    always_comb begin
        int idx;
        grant     = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!any_grant && req[idx]) begin
                any_grant = 1'b1;
                grant     = W'(idx);
            end
        end
    end

endmodule

// File: rtl/receiver.sv
// Switch input stage: arbitrates among neighbour/local ports and moves one flit
// at a time into the downstream flit queue with a request/acknowledge handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for a request; grants a port and latches its flit
// ST_WRITE | flit latched; write it as soon as the queue is not full
// ST_ACK   | flit written; hold r_ready_out[sel] until the sender drops
module receiver
    import receiver_pkg::*;
#(
    parameter int ADDR      = 0,
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int PORTS_NUM = 4,
    localparam int BUS_SIZE = bus_size(DATA_SIZE, ADDR_SIZE)
) (
    input  logic                                 clk,
    input  logic                                 a_rst,
    input  logic [PORTS_NUM:0]                   wr_ready_in,
    input  logic [BUS_SIZE*(PORTS_NUM+1)-1:0]    data_i,
    input  logic                                 mem_full,
    output logic [PORTS_NUM:0]                   r_ready_out,
    output logic [BUS_SIZE-1:0]                  data_o,
    output logic                                 wr_en
);

    localparam int SEL_W = $clog2(PORTS_NUM + 1);

    if (ADDR < 0 || ADDR >= (1 << ADDR_SIZE)) begin : g_addr_chk
        $error("receiver: ADDR does not fit in ADDR_SIZE bits");
    end

    logic [1:0]       state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] rr_ptr;
    logic [PORTS_NUM:0] req;
    logic [SEL_W-1:0] grant;
    logic             any_grant;

    // Floating or unknown request lines must never win arbitration.
    always_comb begin
        req = '0;
        for (int i = 0; i <= PORTS_NUM; i++) begin
            req[i] = (wr_ready_in[i] === 1'b1);
        end
    end

    rr_arbiter #(
        .N (PORTS_NUM + 1),
        .W (SEL_W)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_grant (any_grant)
    );

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state       <= ST_IDLE;
            sel         <= '0;
            rr_ptr      <= '0;
            data_o      <= '0;
            wr_en       <= 1'b0;
            r_ready_out <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_grant) begin
                        data_o <= data_i[int'(grant)*BUS_SIZE +: BUS_SIZE];
                        sel    <= grant;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!mem_full) begin
                        wr_en            <= 1'b1;
                        r_ready_out      <= '0;
                        r_ready_out[sel] <= 1'b1;
                        state            <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!req[sel]) begin
                        r_ready_out <= '0;
                        rr_ptr      <= (sel == SEL_W'(PORTS_NUM)) ? '0 : sel + 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_ready_out <= '0;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: randomized senders and queue back-pressure,
// checked against a transaction-level round-robin model.
module tb_receiver;

    localparam int PORTS = 4;
    localparam int NP    = PORTS + 1;
    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BUS   = DW + AW + 1;

    logic                clk = 1'b0;
    logic                a_rst = 1'b0;
    logic [NP-1:0]       wr_ready_in;
    logic [BUS*NP-1:0]   data_i;
    logic                mem_full;
    logic [NP-1:0]       r_ready_out;
    logic [BUS-1:0]      data_o;
    logic                wr_en;

    receiver #(
        .ADDR      (0),
        .DATA_SIZE (DW),
        .ADDR_SIZE (AW),
        .PORTS_NUM (PORTS)
    ) dut (
        .clk         (clk),
        .a_rst       (a_rst),
        .wr_ready_in (wr_ready_in),
        .data_i      (data_i),
        .mem_full    (mem_full),
        .r_ready_out (r_ready_out),
        .data_o      (data_o),
        .wr_en       (wr_en)
    );

    always #5 clk = ~clk;

    // Reference model: one transfer at a time, round-robin among ports whose
    // request is exactly 1, pointer advances past the port just served.
    int            m_phase;   // 0 free, 1 flit held awaiting queue space, 2 awaiting sender release
    int            m_ptr;
    int            m_port;
    logic [BUS-1:0] m_data;
    logic [NP-1:0] m_ack;
    logic          m_wr;
    int            exp_port[$];
    logic [BUS-1:0] exp_flit[$];

    always @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            m_phase = 0;
            m_ptr   = 0;
            m_port  = 0;
            m_data  = '0;
            m_ack   = '0;
            m_wr    = 1'b0;
        end else begin
            m_wr = 1'b0;
            if (m_phase == 0) begin
                for (int k = 0; k < NP; k++) begin
                    int p;
                    p = (m_ptr + k) % NP;
                    if (m_phase == 0 && wr_ready_in[p] === 1'b1) begin
                        m_port  = p;
                        m_data  = data_i[p*BUS +: BUS];
                        m_phase = 1;
                        exp_port.push_back(p);
                        exp_flit.push_back(m_data);
                    end
                end
            end else if (m_phase == 1) begin
                if (!mem_full) begin
                    m_wr    = 1'b1;
                    m_ack   = NP'(1) << m_port;
                    m_phase = 2;
                end
            end else begin
                if (wr_ready_in[m_port] !== 1'b1) begin
                    m_ack   = '0;
                    m_ptr   = (m_port + 1) % NP;
                    m_phase = 0;
                end
            end
        end
    end

    // Monitor: compares DUT outputs with the model and pops the scoreboard on writes.
    int   checks = 0;
    int   failures = 0;
    int   rd_idx = 0;
    logic prev_wr = 1'b0;
    logic end_chk = 1'b0;
    logic end_done = 1'b0;

    always @(negedge clk or posedge a_rst) begin
        if (a_rst) begin
            #1;
            checks += 1;
            if (r_ready_out !== '0 || wr_en !== 1'b0 || data_o !== '0) begin
                failures += 1;
                $display("FAIL reset_outputs: got r_ready_out=%b wr_en=%b data_o=%h, want all zero",
                         r_ready_out, wr_en, data_o);
            end
            rd_idx  = exp_port.size();
            prev_wr = 1'b0;
        end else begin
            checks += 1;
            if (wr_en !== m_wr) begin
                failures += 1;
                $display("FAIL wr_en_timing @%0t: got %b want %b", $time, wr_en, m_wr);
            end
            checks += 1;
            if (r_ready_out !== m_ack) begin
                failures += 1;
                $display("FAIL r_ready_out @%0t: got %b want %b", $time, r_ready_out, m_ack);
            end
            checks += 1;
            if (data_o !== m_data) begin
                failures += 1;
                $display("FAIL data_o @%0t: got %h want %h", $time, data_o, m_data);
            end
            checks += 1;
            if ($countones(r_ready_out) > 1 || (wr_en === 1'b1 && prev_wr === 1'b1)) begin
                failures += 1;
                $display("FAIL invariants @%0t: r_ready_out=%b wr_en=%b prev_wr_en=%b",
                         $time, r_ready_out, wr_en, prev_wr);
            end
            if (wr_en === 1'b1) begin
                checks += 1;
                if (rd_idx >= exp_port.size()) begin
                    failures += 1;
                    $display("FAIL sb_empty @%0t: write of %h with nothing expected", $time, data_o);
                end else begin
                    if (data_o !== exp_flit[rd_idx] || r_ready_out !== (NP'(1) << exp_port[rd_idx])) begin
                        failures += 1;
                        $display("FAIL sb_flit @%0t: got flit %h ack %b want flit %h from port %0d",
                                 $time, data_o, r_ready_out, exp_flit[rd_idx], exp_port[rd_idx]);
                    end
                    rd_idx += 1;
                end
            end
            prev_wr = wr_en;
            if (end_chk && !end_done) begin
                checks += 1;
                if (rd_idx != exp_port.size()) begin
                    failures += 1;
                    $display("FAIL sb_drain: written %0d want %0d granted flits", rd_idx, exp_port.size());
                end
                end_done = 1'b1;
            end
        end
    end

    // Sender behaviour per port: offer a flit, drop the request once it is taken.
    logic gen_en;
    logic drop_en;
    int   hold[NP];

    task automatic sender_step();
        logic [63:0] r;
        for (int p = 0; p < NP; p++) begin
            if (wr_ready_in[p] === 1'b1) begin
                if (drop_en && r_ready_out[p] === 1'b1) begin
                    wr_ready_in[p] = 1'b0;
                    hold[p]        = $urandom_range(1, 3);
                end
            end else if (hold[p] != 0) begin
                hold[p] = hold[p] - 1;
            end else if (gen_en && $urandom_range(0, 3) == 0) begin
                r = {$urandom, $urandom};
                data_i[p*BUS +: BUS] = r[BUS-1:0];
                wr_ready_in[p]       = 1'b1;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sender_step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 a_rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 a_rst = 1'b0;
    endtask

    initial begin
        logic [BUS-1:0] f;
        wr_ready_in = '0;
        data_i      = '0;
        mem_full    = 1'b0;
        gen_en      = 1'b0;
        drop_en     = 1'b1;
        for (int p = 0; p < NP; p++) hold[p] = 0;

        #2 a_rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 a_rst = 1'b0;

        // Single flit 0x15 on port 2, queue empty.
        @(negedge clk);
        f = BUS'(8'h15);
        data_i[2*BUS +: BUS] = f;
        wr_ready_in[2] = 1'b1;
        repeat (8) step();

        // Ports 0, 1, 4 together straight after reset: expect 0, 1, 4.
        do_reset();
        @(negedge clk);
        data_i[0*BUS +: BUS] = BUS'(37'h0A0A0A0A0);
        data_i[1*BUS +: BUS] = BUS'(37'h0B1B1B1B1);
        data_i[4*BUS +: BUS] = BUS'(37'h1C4C4C4C4);
        wr_ready_in[0] = 1'b1;
        wr_ready_in[1] = 1'b1;
        wr_ready_in[4] = 1'b1;
        repeat (16) step();

        // Queue full across the write window, then released.
        @(negedge clk);
        mem_full = 1'b1;
        data_i[3*BUS +: BUS] = BUS'(37'h123456789);
        wr_ready_in[3] = 1'b1;
        repeat (6) step();
        mem_full = 1'b0;
        repeat (6) step();

        // Floating request line on port 3 must not be granted.
        @(negedge clk);
        wr_ready_in[3] = 1'bz;
        repeat (10) step();
        wr_ready_in[3] = 1'b0;

        // Reset while acknowledging port 1, which keeps requesting.
        drop_en = 1'b0;
        @(negedge clk);
        data_i[1*BUS +: BUS] = BUS'(37'h0DEADBEEF);
        wr_ready_in[1] = 1'b1;
        repeat (2) @(negedge clk);
        #2 a_rst = 1'b1;
        @(negedge clk);
        #2 a_rst = 1'b0;
        drop_en = 1'b1;
        repeat (10) step();

        // Randomized traffic with random back-pressure.
        gen_en = 1'b1;
        repeat (3000) begin
            step();
            mem_full = ($urandom_range(0, 3) == 0);
        end
        gen_en   = 1'b0;
        mem_full = 1'b0;
        repeat (40) step();

        end_chk = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter ADDR, 0, address of the owning switch node.
REQ-002 Parameter DATA_SIZE, 32, flit payload width.
REQ-003 Parameter ADDR_SIZE, 4, destination address field width.
REQ-004 Parameter PORTS_NUM, 4, number of neighbour ports; index PORTS_NUM is the local core port.
REQ-005 Derived constant BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1, flit bus width.
REQ-006 clk  input  1  clock; all state changes on rising edge.
REQ-007 a_rst  input  1  reset, asynchronous, active-high.
REQ-008 wr_ready_in  input  PORTS_NUM+1  per-port "flit offered" from the upstream sender.
REQ-009 data_i  input  BUS_SIZE*(PORTS_NUM+1)  per-port flit buses; port p occupies bits [p*BUS_SIZE +: BUS_SIZE].
REQ-010 mem_full  input  1  downstream flit queue cannot accept a write.
REQ-011 r_ready_out  output  PORTS_NUM+1  per-port "flit taken" acknowledge to the sender.
REQ-012 data_o  output  BUS_SIZE  flit presented to the queue.
REQ-013 wr_en  output  1  single-cycle queue write strobe, qualifies data_o.

Function
REQ-014 Registered FSM with states IDLE, WRITE, ACK; every output is registered.
REQ-015 A port counts as requesting only when its wr_ready_in bit is exactly 1; 0, x or z (unconnected port) counts as not requesting.
REQ-016 IDLE: if any port requests, select the first requesting port at or after rr_ptr in ascending order, wrapping from PORTS_NUM to 0; latch its flit into data_o, store its index in sel, go to WRITE; otherwise stay in IDLE.
REQ-017 WRITE with mem_full=0: assert wr_en for exactly one cycle, set r_ready_out[sel]=1, go to ACK.
REQ-018 WRITE with mem_full=1: hold state and data_o, keep wr_en=0; no flit is ever written while full.
REQ-019 ACK: hold r_ready_out[sel]=1 until wr_ready_in[sel] !== 1; then clear r_ready_out[sel], set rr_ptr = sel+1 (sel=PORTS_NUM wraps to 0), go to IDLE.
REQ-020 Latency: request sampled at edge N gives data_o valid after N; with queue not full, wr_en and r_ready_out high after N+1; earliest next grant at N+3.
REQ-021 At most one r_ready_out bit is high at any time; wr_en is never high in two consecutive cycles.
REQ-022 A wr_ready_in[sel] drop during WRITE does not cancel the write; the latched flit is still written.
REQ-023 Requests on non-selected ports are ignored until the FSM returns to IDLE; no flit is lost or duplicated.
REQ-024 data_o is passed through unmodified; routing decisions belong to the transmit stage.
REQ-025 An illegal state encoding returns the FSM to IDLE on the next edge.

Reset
REQ-026 a_rst forces the FSM to IDLE immediately, including mid-transfer.
REQ-027 Reset values: r_ready_out=0, wr_en=0, data_o=0, rr_ptr=0, sel=0.
REQ-028 After reset deassertion, the first grant occurs no earlier than the first rising edge.

Structure
REQ-029 State encodings and the BUS_SIZE derivation live in the shared switch package/header and are also used by the transmit stage.
REQ-030 Port selection is the combinational sub-module rr_arbiter (inputs: request vector, pointer; outputs: grant index, any-grant).

Verification
REQ-031 PORTS_NUM=4, port 2 offers flit 0x15 with queue empty -> data_o=0x15 after N, wr_en=1 one cycle after N+1, r_ready_out=5'b00100 until wr_ready_in[2] drops.
REQ-032 Ports 0, 1 and 4 request simultaneously, rr_ptr=0 -> grant order 0, 1, 4, then 0 again if port 0 re-requests.
REQ-033 mem_full=1 for 5 cycles during WRITE -> wr_en=0 and r_ready_out=0 throughout; write occurs one cycle after mem_full falls.
REQ-034 wr_ready_in[3]=z, other ports idle -> no grant, outputs stay 0.
REQ-035 a_rst pulsed while in ACK on port 1 -> r_ready_out=0, wr_en=0, rr_ptr=0 immediately; port 1 is re-granted once reset releases if still requesting.
